mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single 64-bit virtual-memory port (the DPI vmem read/write path) between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time through valid/ready handshakes, drives it to memory, and routes the response back to its owner.
- Sits between the core front/back end and the memory wrapper; it is the precursor to a multi-cycle core.

Parameters:
- ADDR_W, 64, address width of all ports
- DATA_W, 64, data width of all ports; DATA_W/8 byte-mask bits

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU response strobe
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  LSU write data
- lsu_wmask  in  DATA_W/8  LSU byte mask
- lsu_resp_valid  out  1  LSU response strobe (read data or write ack)
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  latched address
- mem_wen  out  1  latched write enable (always 0 for IFU)
- mem_wdata  out  DATA_W  latched write data
- mem_wmask  out  DATA_W/8  latched mask (0 for IFU)
- mem_resp_valid  in  1  memory response strobe
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. Registers: state, owner (0 = IFU, 1 = LSU), last_grant, and latched addr/wen/wdata/wmask.
- Reset (async, rst=1):
  - state=IDLE, owner=0, last_grant=0, latched fields=0.
  - All outputs 0: req_ready, resp_valid, mem_req_valid.
- IDLE:
  - Grant is combinational. LSU wins whenever lsu_req_valid=1; otherwise IFU if ifu_req_valid=1.
  - The winner's req_ready=1 in the same cycle. The loser's req_ready=0.
  - On the grant edge: latch the winner's fields (IFU forces wen=0, wmask=0), set owner, update last_grant, go to ISSUE.
  - No valid request: stay in IDLE.
- req_ready is 1 only in IDLE and only for the granted requester. A requester holds valid and its fields stable until ready.
- ISSUE:
  - mem_req_valid=1; mem_* outputs are driven from the latched registers only.
  - When mem_req_ready=1, go to WAIT; otherwise stay and keep outputs stable.
- WAIT:
  - On mem_resp_valid=1: owner's resp_valid=1 for exactly that cycle; rdata = mem_rdata passed combinationally; go to IDLE.
  - The non-owner's resp_valid stays 0.
- rdata outputs:
  - ifu_rdata and lsu_rdata always mirror mem_rdata; they are qualified only by resp_valid.
  - For writes, lsu_resp_valid is an ack and rdata is don't-care.
- Latency:
  - Request accepted in cycle N; mem_req_valid asserted in N+1.
  - With mem_req_ready=1 and memory responding one cycle later, resp_valid is asserted in N+2.
  - Back-to-back throughput is one transaction per 3 cycles minimum.
- Boundary conditions:
  - mem_resp_valid in IDLE or ISSUE is ignored and produces no resp_valid.
  - Requests arriving while not IDLE see ready=0 and wait.
  - A new request is accepted only after returning to IDLE, i.e. the cycle after the response.
  - Reset mid-transaction aborts it: no response is delivered, and any later mem_resp_valid is ignored.
  - Simultaneous IFU and LSU valid: per arbitration policy below.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin when both requesters are valid. The grant goes to the requester not recorded in last_grant. last_grant resets to 0 (IFU), so the LSU wins the first tie.
- Undefined: fixed priority, LSU always wins. last_grant is still maintained but unused.
- A single valid requester is always granted in both modes.

Test Plan:
- Reset, then IFU read of addr 0x80000000. mem_req_ready=1, memory returns 0x0000_0013_0000_0093 one cycle after the request → ifu_resp_valid=1 for 1 cycle with that data; cycle count from accept to response = 2; lsu_resp_valid stays 0.
- LSU write: addr 0x80001000, wdata 0x1122334455667788, wmask 0x0f → mem_wen=1 and mem_wmask=0x0f observed with exact data; lsu_resp_valid pulses once on the ack.
- IFU and LSU both valid for 4 consecutive transactions. Without ARB_RR_EN: LSU is granted all 4 while IFU waits. With ARB_RR_EN: grant order LSU, IFU, LSU, IFU.
- mem_req_ready held 0 for 5 cycles in ISSUE → mem_req_valid stays 1 with stable addr/data for all 5; both req_ready stay 0.
- Stray mem_resp_valid pulse in IDLE → no resp_valid on either side; FSM stays in IDLE.
- Assert rst while in WAIT, release, then deliver mem_resp_valid → no resp_valid; all outputs 0 during reset; next IFU request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between IFU reads and LSU reads/writes, one transaction at a time.
// Define ARB_RR_EN for round-robin on ties; otherwise the LSU has fixed priority.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_rdata,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wmask_q, wmask_d;
   logic                grant_ifu, grant_lsu;

   always_comb begin
`ifdef ARB_RR_EN
      // On a tie the requester not served last time wins.
      grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_grant_q);
`else
      grant_lsu = lsu_req_valid;
`endif
      grant_ifu = ifu_req_valid & ~grant_lsu;
   end

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      last_grant_d   = last_grant_q;
      addr_d         = addr_q;
      wen_d          = wen_q;
      wdata_d        = wdata_q;
      wmask_d        = wmask_q;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      mem_req_valid  = 1'b0;
      case (state_q)
         StIdle: begin
            // Ready is masked while reset is held so no grant is advertised.
            ifu_req_ready = grant_ifu & ~rst;
            lsu_req_ready = grant_lsu & ~rst;
            if (grant_lsu) begin
               owner_d      = 1'b1;
               last_grant_d = 1'b1;
               addr_d       = lsu_addr;
               wen_d        = lsu_wen;
               wdata_d      = lsu_wdata;
               wmask_d      = lsu_wmask;
               state_d      = StIssue;
            end else if (grant_ifu) begin
               owner_d      = 1'b0;
               last_grant_d = 1'b0;
               addr_d       = ifu_addr;
               wen_d        = 1'b0;
               wdata_d      = '0;
               wmask_d      = '0;
               state_d      = StIssue;
            end
         end
         StIssue: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = StWait;
         end
         StWait: begin
            if (mem_resp_valid) begin
               ifu_resp_valid = ~owner_q;
               lsu_resp_valid = owner_q;
               state_d        = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b0;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wen   = wen_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign ifu_rdata = mem_rdata;
   assign lsu_rdata = mem_rdata;

endmodule
